tsmac_apb_arbiter: RTL and testbench
====================================

Name: tsmac_apb_arbiter

Overview:
- Shares the single TSMAC APB register port between two requesters.
- Requester 0 is the power-up configuration sequencer; requester 1 is the runtime host/status poller.
- Each requester issues one-word read or write commands over a req/ack interface. The block arbitrates between them, runs standard APB SETUP/ACCESS phases with pready wait-states, and returns read data.
- Includes a transfer timeout so a stalled slave cannot hang the configuration sequence.

Parameters:
- ARB_MODE, 0, 0 = fixed priority (req0 wins); 1 = round-robin (alternates on simultaneous requests).
- TIMEOUT_CYC, 255, ACCESS cycles with pready low before abort; 1..1023.
- TIMEOUT_DATA, 32'hDEAD_BEEF, rdata value returned on timeout.

Ports:
- pclk input 1 APB clock
- presetn input 1 asynchronous reset, active-high
- req0 input 1 requester 0 command valid
- wr0 input 1 requester 0: 1 = write, 0 = read
- addr0 input 8 requester 0 register address
- wdata0 input 32 requester 0 write data
- ack0 output 1 requester 0 done pulse
- req1 input 1 requester 1 command valid
- wr1 input 1 requester 1: 1 = write, 0 = read
- addr1 input 8 requester 1 register address
- wdata1 input 32 requester 1 write data
- ack1 output 1 requester 1 done pulse
- rdata output 32 read data, valid with ack
- err output 1 timeout flag, valid with ack
- lock0 input 1 bus lock request from requester 0 (used only with optional feature)
- pselx output 1 APB select
- penable output 1 APB enable
- pwrite output 1 APB direction
- paddr output 8 APB address
- pwdata output 32 APB write data
- prdata input 32 APB read data
- pready input 1 APB slave ready

Behaviour:
- Reset (async, presetn=1):
  - All outputs 0; state IDLE.
  - Round-robin pointer points to requester 0.
  - Timeout counter 0.
  - Asserting reset mid-transfer drops pselx/penable immediately. No ack is issued for the aborted transfer.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - Eligible request = reqN high and ackN low in the same cycle. Requesters hold reqN until they see ackN, so this masking is what prevents re-granting a just-completed request.
  - No eligible request: stay in IDLE; pselx=0, penable=0.
  - Winner selection:
    - ARB_MODE=0: req0 wins.
    - ARB_MODE=1: on a tie, the requester not granted last wins. A lone request always wins.
  - On the registered edge: latch the winner's wr/addr/wdata into pwrite/paddr/pwdata, set pselx=1, go to SETUP.
- SETUP (exactly 1 cycle): pselx=1, penable=0. Next state ACCESS with penable=1.
- ACCESS:
  - pselx=1 and penable=1; paddr, pwrite and pwdata are held stable.
  - pready=1 sampled:
    - Next cycle: ackN=1 for one cycle, err=0. rdata=prdata on a read; rdata holds its previous value on a write.
    - pselx and penable return to 0; state returns to IDLE.
  - pready=0: increment the timeout counter.
  - Counter reaches TIMEOUT_CYC without pready:
    - Next cycle: ackN=1, err=1, rdata=TIMEOUT_DATA.
    - pselx and penable return to 0; state returns to IDLE.
  - Counter clears on every SETUP entry.
- Latency: zero-wait-state transfer from reqN high in IDLE to ackN high is 3 cycles. Each pready-low cycle adds 1.
- pwdata is driven to 0 whenever pselx=0. The grant pointer updates on entry to SETUP.
- Request changes while a transfer is in flight are ignored until IDLE. A requester dropping reqN mid-transfer still receives its ack.
- rdata and err hold their values until the next ack.

Optional Feature:
- Macro TSMAC_ARB_LOCK_EN.
- Defined:
  - While lock0=1 at an IDLE decision, requester 0 is the only eligible requester. req1 waits even under round-robin.
  - This lets the config sequencer issue its consecutive writes (MAC1, MAC2, filter, MAC_L, MAC_H) atomically.
  - A lock0 rising edge while requester 1 is in flight takes effect at the next IDLE.
- Not defined: lock0 is ignored (left unconnected internally); arbitration follows ARB_MODE only.

Test Plan:
- Fixed-priority tie: ARB_MODE=0; req0 write addr 8'h01 data 32'h0000_7217 and req1 read addr 8'h13 asserted together; pready=1 -> req0 APB write completes first, ack0 on cycle 3, then req1 read, ack1 with rdata=prdata=32'h1020_3040.
- Round-robin fairness: ARB_MODE=1; req0 and req1 held high for 4 transfers each -> grants alternate 0,1,0,1; no requester is granted twice in a row.
- Wait states: single req1 read, pready low for 5 ACCESS cycles -> pselx/penable/paddr stable for 6 ACCESS cycles; ack1 on cycle 8; err=0.
- Timeout: TIMEOUT_CYC=16, pready tied 0 -> ack high on cycle 16 after ACCESS entry; err=1; rdata=32'hDEAD_BEEF; bus idle next cycle; next request proceeds normally.
- Reset mid-ACCESS: presetn pulsed during ACCESS of a write -> pselx, penable, pwdata and ack0 go 0 asynchronously; after release, FSM in IDLE and re-grants the still-high req0.
- Lock (TSMAC_ARB_LOCK_EN defined): lock0=1, req0 issues 5 back-to-back writes while req1 is held high -> all 5 req0 transfers complete before the first ack1.

Source files
------------

// File: rtl/tsmac_apb_arbiter.sv
// ---------------------------------------------------------------------------
// tsmac_apb_arbiter
//   Shares the single TSMAC APB register port between two requesters:
//   requester 0 is the power-up configuration sequencer and requester 1 is
//   the runtime host/status poller. Each requester posts one-word read or
//   write commands on a req/ack handshake. The block picks a winner in IDLE,
//   runs the APB SETUP and ACCESS phases, honours pready wait-states and
//   aborts a transfer that waits too long. A timed-out transfer returns
//   TIMEOUT_DATA with err set.
//
//   Optional feature (macro TSMAC_ARB_LOCK_EN): while lock0 is high at an
//   IDLE decision, only requester 0 can be granted. This keeps a burst of
//   configuration writes atomic. Without the macro, lock0 is ignored.
//
// Parameters
//   ARB_MODE     0 = fixed priority (req0 wins), 1 = round-robin on ties
//   TIMEOUT_CYC  ACCESS cycles with pready low before abort (1..1023)
//   TIMEOUT_DATA rdata value returned on a timeout
//
// Ports
//   pclk, presetn            clock; asynchronous active-high reset
//   reqN/wrN/addrN/wdataN    requester N command (held until ackN)
//   ackN                     one-cycle done pulse for requester N
//   rdata, err               read data / timeout flag, valid with ack
//   lock0                    bus lock from requester 0 (optional feature)
//   pselx..pwdata            APB master outputs
//   prdata, pready           APB slave response
// ---------------------------------------------------------------------------
module tsmac_apb_arbiter #(
  parameter int          ARB_MODE     = 0,
  parameter int          TIMEOUT_CYC  = 255,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        req0,
  input  logic        wr0,
  input  logic [7:0]  addr0,
  input  logic [31:0] wdata0,
  output logic        ack0,
  input  logic        req1,
  input  logic        wr1,
  input  logic [7:0]  addr1,
  input  logic [31:0] wdata1,
  output logic        ack1,
  output logic [31:0] rdata,
  output logic        err,
  input  logic        lock0,
  output logic        pselx,
  output logic        penable,
  output logic        pwrite,
  output logic [7:0]  paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYC - 1);

  state_t     state;
  logic [9:0] tmo_cnt;
  logic       rr_ptr;   // requester preferred on the next tie
  logic       owner;    // requester that owns the current transfer
  logic       elig0;
  logic       elig1;
  logic       win;

  // A request is masked during its own ack cycle: requesters hold reqN until
  // they see ackN, so without the mask a finished command would be re-granted.
  assign elig0 = req0 & ~ack0;
`ifdef TSMAC_ARB_LOCK_EN
  assign elig1 = req1 & ~ack1 & ~lock0;
`else
  logic unused_lock0;
  assign unused_lock0 = lock0;
  assign elig1 = req1 & ~ack1;
`endif

  always_comb begin
    win = 1'b0;
    if (elig0 && elig1)
      win = (ARB_MODE == 1) ? rr_ptr : 1'b0;
    else if (elig1)
      win = 1'b1;
  end

  always_ff @(posedge pclk or posedge presetn) begin
    if (presetn) begin
      state   <= IDLE;
      tmo_cnt <= '0;
      rr_ptr  <= 1'b0;
      owner   <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
      pselx   <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (elig0 || elig1) begin
            owner   <= win;
            rr_ptr  <= ~win;
            pselx   <= 1'b1;
            pwrite  <= win ? wr1    : wr0;
            paddr   <= win ? addr1  : addr0;
            pwdata  <= win ? wdata1 : wdata0;
            tmo_cnt <= '0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // pready takes precedence over a timeout landing in the same cycle.
          if (pready || (tmo_cnt == TMO_LAST)) begin
            ack0    <= ~owner;
            ack1    <= owner;
            err     <= ~pready;
            if (!pready)
              rdata <= TIMEOUT_DATA;
            else if (!pwrite)
              rdata <= prdata;
            pselx   <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 10'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tsmac_apb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tsmac_apb_arbiter
//   Two arbiter instances (fixed priority and round-robin), each with its own
//   randomized requesters, APB slave and reference model. The bus process
//   predicts every grant from the arbitration rules and pushes the expected
//   ack (cycle, rdata, err) into a per-requester queue; a separate ack monitor
//   pops and compares whenever an ack appears.
// ---------------------------------------------------------------------------
module tb_tsmac_apb_arbiter;

  localparam int          TMO   = 16;
  localparam logic [31:0] TDATA = 32'hDEAD_BEEF;
  localparam int          NXFER = 24;
`ifdef TSMAC_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_chk  = 0;
  int n_pass = 0;
  bit done [2];

  task automatic check(input int inst, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL u%0d %s: got %h expected %h", inst, name, act, exp);
  endtask

  // Slave register contents: a fixed function of the address.
  function automatic logic [31:0] slave_data(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, 8'h3C};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic        presetn;
    logic        req0, wr0, req1, wr1, lock0, pready;
    logic [7:0]  addr0, addr1, paddr;
    logic [31:0] wdata0, wdata1, prdata, rdata, pwdata;
    logic        ack0, ack1, err, pselx, penable, pwrite;

    tsmac_apb_arbiter #(
      .ARB_MODE    (g),
      .TIMEOUT_CYC (TMO),
      .TIMEOUT_DATA(TDATA)
    ) u_dut (
      .pclk   (pclk),
      .presetn(presetn),
      .req0   (req0),
      .wr0    (wr0),
      .addr0  (addr0),
      .wdata0 (wdata0),
      .ack0   (ack0),
      .req1   (req1),
      .wr1    (wr1),
      .addr1  (addr1),
      .wdata1 (wdata1),
      .ack1   (ack1),
      .rdata  (rdata),
      .err    (err),
      .lock0  (lock0),
      .pselx  (pselx),
      .penable(penable),
      .pwrite (pwrite),
      .paddr  (paddr),
      .pwdata (pwdata),
      .prdata (prdata),
      .pready (pready)
    );

    typedef struct {
      int          due;
      logic [31:0] rdata;
      logic        err;
    } resp_t;

    resp_t       rq0[$];
    resp_t       rq1[$];
    int          cyc = 0;
    bit          force_stall = 1'b0;
    logic [31:0] pred_rdata = '0;

    always @(posedge pclk) cyc <= cyc + 1;

    // Post one command and hold it until its ack is seen.
    task automatic issue(input int r, input logic w, input logic [7:0] a,
                         input logic [31:0] d);
      bit seen = 1'b0;
      if (r == 0) begin req0 = 1'b1; wr0 = w; addr0 = a; wdata0 = d; end
      else        begin req1 = 1'b1; wr1 = w; addr1 = a; wdata1 = d; end
      for (int i = 0; i < 3000 && !seen; i++) begin
        @(negedge pclk);
        seen = (r == 0) ? ack0 : ack1;
      end
      check(g, "ack_wait", seen, 1);
      @(posedge pclk);
      #1;
    endtask

    task automatic run_req(input int r);
      int gap;
      for (int k = 0; k < NXFER; k++) begin
        gap = $urandom_range(0, 3);
        if (r == 0) lock0 = LOCK_EN ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
        issue(r, 1'($urandom_range(0, 1)), {r[0], 7'($urandom)}, $urandom);
        if (gap != 0) begin
          if (r == 0) req0 = 1'b0; else req1 = 1'b0;
          repeat (gap) @(posedge pclk);
          #1;
        end
      end
      if (r == 0) begin req0 = 1'b0; lock0 = 1'b0; end
      else req1 = 1'b0;
    endtask

    // Control: reset check, random traffic, reset during ACCESS.
    initial begin
      bit hit;
      presetn = 1'b1;
      req0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0; lock0 = 1'b0;
      req1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
      repeat (3) @(negedge pclk);
      check(g, "reset_bus", {pselx, penable, pwrite, ack0, ack1, err, paddr, pwdata}, '0);
      check(g, "reset_rdata", rdata, '0);
      @(posedge pclk);
      #1 presetn = 1'b0;

      fork
        run_req(0);
        run_req(1);
      join

      repeat (3) @(posedge pclk);
      #1;
      force_stall = 1'b1;
      req0 = 1'b1; wr0 = 1'b1; addr0 = 8'h21; wdata0 = 32'hA5A5_0F0F; lock0 = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 50 && !hit; i++) begin
        @(negedge pclk);
        hit = pselx & penable;
      end
      check(g, "reach_access", hit, 1);
      repeat (2) @(posedge pclk);
      #3 presetn = 1'b1;
      #1 check(g, "reset_async_drop", {pselx, penable, ack0, pwdata}, '0);
      @(posedge pclk);
      #1 presetn = 1'b0;
      force_stall = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
        @(negedge pclk);
        hit = ack0;
      end
      check(g, "regrant_after_reset", hit, 1);
      @(posedge pclk);
      #1 req0 = 1'b0;
      repeat (4) @(posedge pclk);
      check(g, "resp_queues_drained", rq0.size() + rq1.size(), 0);
      done[g] = 1'b1;
    end

    // Bus monitor, arbitration model and APB slave.
    initial begin
      bit          p_idle, p_e0, p_e1, rr_pref, stall, setup;
      int          waits, wcnt, w;
      logic        x_wr;
      logic [7:0]  x_addr;
      logic [31:0] x_wdata;
      resp_t       rs;
      p_idle = 1'b0; p_e0 = 1'b0; p_e1 = 1'b0; rr_pref = 1'b0; stall = 1'b0;
      waits = 0; wcnt = 0; x_wr = 1'b0; x_addr = '0; x_wdata = '0;
      pready = 1'b0; prdata = '0;
      forever begin
        @(negedge pclk);
        if (presetn) begin
          p_idle = 1'b0; rr_pref = 1'b0; pred_rdata = '0;
          rq0.delete(); rq1.delete(); pready = 1'b0;
        end else begin
          if (!pselx) check(g, "pwdata_idle_zero", pwdata, '0);
          if (p_idle) begin
            setup = pselx & ~penable;
            check(g, "grant_decision", setup, p_e0 | p_e1);
            if (setup && (p_e0 || p_e1)) begin
              w = (p_e0 && p_e1) ? ((g == 1) ? int'(rr_pref) : 0) : (p_e1 ? 1 : 0);
              x_wr    = (w == 1) ? wr1    : wr0;
              x_addr  = (w == 1) ? addr1  : addr0;
              x_wdata = (w == 1) ? wdata1 : wdata0;
              check(g, "grant_winner", paddr[7], w[0]);
              check(g, "grant_cmd", {pwrite, paddr, pwdata}, {x_wr, x_addr, x_wdata});
              rr_pref  = ~w[0];
              stall    = force_stall || ($urandom_range(0, 9) == 0);
              waits    = $urandom_range(0, 4);
              wcnt     = 0;
              rs.due   = cyc + (stall ? TMO + 1 : 2 + waits);
              rs.err   = stall;
              rs.rdata = stall ? TDATA : (x_wr ? pred_rdata : slave_data(x_addr));
              pred_rdata = rs.rdata;
              if (w == 1) rq1.push_back(rs); else rq0.push_back(rs);
            end
          end
          if (pselx && penable) begin
            check(g, "access_stable", {pwrite, paddr, pwdata}, {x_wr, x_addr, x_wdata});
            pready = !stall && (wcnt >= waits);
            if (!pready) wcnt++;
          end else begin
            pready = 1'($urandom_range(0, 1));
          end
          prdata = pready ? slave_data(paddr) : $urandom;
          p_idle = !pselx;
        end
        p_e0 = req0 & ~ack0;
        p_e1 = req1 & ~ack1 & ~(LOCK_EN & lock0);
      end
    end

    // Ack monitor: pops the expected response when an ack appears.
    initial begin
      resp_t rs;
      forever begin
        @(negedge pclk);
        if (!presetn) begin
          if (ack0) begin
            if (rq0.size() == 0) check(g, "ack0_unexpected", ack0, 0);
            else begin
              rs = rq0.pop_front();
              check(g, "ack0_cycle", cyc, rs.due);
              check(g, "ack0_rdata", rdata, rs.rdata);
              check(g, "ack0_err", err, rs.err);
            end
          end
          if (ack1) begin
            if (rq1.size() == 0) check(g, "ack1_unexpected", ack1, 0);
            else begin
              rs = rq1.pop_front();
              check(g, "ack1_cycle", cyc, rs.due);
              check(g, "ack1_rdata", rdata, rs.rdata);
              check(g, "ack1_err", err, rs.err);
            end
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 60000 && !(done[0] && done[1]); i++) @(posedge pclk);
    check(-1, "run_complete", {done[0], done[1]}, 2'b11);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
